// File: rtl/collatz_pkg.sv
// Shared definitions for the collatz range-sweep controller: default widths,
// watchdog limit and FSM state encoding.
package collatz_pkg;

    localparam int unsigned DefaultWidth   = 32;
    localparam int unsigned DefaultTimeout = 65536;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StKrst   = 3'd1,
        StKstart = 3'd2,
        StWait   = 3'd3,
        StAcc    = 3'd4,
        StDone   = 3'd5
    } state_e;

endpackage

// File: rtl/collatz_sweep_best.sv
// Running-best tracker: keeps the largest step count seen and the first n that
// produced it; strict compare so ties keep the earlier (smaller) n.
module collatz_sweep_best
    import collatz_pkg::*;
#(
    parameter int unsigned W = DefaultWidth
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         upd,
    input  logic [W-1:0] cand_n,
    input  logic [W-1:0] cand_steps,
    output logic [W-1:0] max_steps,
    output logic [W-1:0] argmax
);

    logic [W-1:0] max_q, max_d;
    logic [W-1:0] argmax_q, argmax_d;

    always_comb begin
        max_d    = max_q;
        argmax_d = argmax_q;
        if (clr) begin
            max_d    = '0;
            argmax_d = '0;
        end else if (upd && (cand_steps > max_q)) begin
            max_d    = cand_steps;
            argmax_d = cand_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_q    <= '0;
            argmax_q <= '0;
        end else begin
            max_q    <= max_d;
            argmax_q <= argmax_d;
        end
    end

    assign max_steps = max_q;
    assign argmax    = argmax_q;

endmodule

// File: rtl/collatz_sweep.sv
// Range-sweep controller feeding one external collatz kernel n_lo..n_hi.
// Optional per-item watchdog enabled by defining COLLATZ_SWEEP_TIMEOUT_EN.
module collatz_sweep
    import collatz_pkg::*;
#(
    parameter int unsigned W              = DefaultWidth,
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeout
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] n_lo,
    input  logic [W-1:0] n_hi,
    output logic         busy,
    output logic         finish,
    output logic [W-1:0] ret_max_steps,
    output logic [W-1:0] ret_argmax,
    output logic [W-1:0] ret_count,
    output logic [W-1:0] ret_timeouts,
    output logic         kern_rst_n,
    output logic         kern_start,
    output logic [W-1:0] kern_n,
    input  logic         kern_finish,
    input  logic [W-1:0] kern_ret
);

    state_e       state_q, state_d;
    logic [W-1:0] n_hi_q, n_hi_d;
    logic [W-1:0] cur_n_q, cur_n_d;
    logic [W-1:0] kern_n_q, kern_n_d;
    logic [W-1:0] ret_q, ret_d;
    logic [W-1:0] count_q, count_d;
    logic         busy_q, busy_d;
    logic         finish_q, finish_d;
    logic         timed_out_q, timed_out_d;
    logic         best_clr, best_upd;

`ifdef COLLATZ_SWEEP_TIMEOUT_EN
    logic [W-1:0] wdog_q, wdog_d;
    logic [W-1:0] timeouts_q, timeouts_d;
`endif

    always_comb begin
        state_d     = state_q;
        n_hi_d      = n_hi_q;
        cur_n_d     = cur_n_q;
        kern_n_d    = kern_n_q;
        ret_d       = ret_q;
        count_d     = count_q;
        busy_d      = busy_q;
        finish_d    = finish_q;
        timed_out_d = timed_out_q;
        best_clr    = 1'b0;
        best_upd    = 1'b0;
`ifdef COLLATZ_SWEEP_TIMEOUT_EN
        wdog_d      = wdog_q;
        timeouts_d  = timeouts_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                // busy still set in DONE only after an empty-range start
                if ((state_q == StDone) && busy_q) begin
                    busy_d   = 1'b0;
                    finish_d = 1'b1;
                end else if (start) begin
                    n_hi_d   = n_hi;
                    cur_n_d  = n_lo;
                    count_d  = '0;
                    busy_d   = 1'b1;
                    finish_d = 1'b0;
                    best_clr = 1'b1;
`ifdef COLLATZ_SWEEP_TIMEOUT_EN
                    timeouts_d = '0;
`endif
                    state_d  = (n_lo > n_hi) ? StDone : StKrst;
                end
            end
            StKrst: begin
                kern_n_d = cur_n_q;
                state_d  = StKstart;
            end
            StKstart: begin
`ifdef COLLATZ_SWEEP_TIMEOUT_EN
                wdog_d = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
                if (kern_finish == 1'b1) begin
                    ret_d       = kern_ret;
                    timed_out_d = 1'b0;
                    state_d     = StAcc;
                end
`ifdef COLLATZ_SWEEP_TIMEOUT_EN
                else if (wdog_q == W'(TIMEOUT_CYCLES - 1)) begin
                    timed_out_d = 1'b1;
                    state_d     = StAcc;
                end else begin
                    wdog_d = wdog_q + W'(1);
                end
`endif
            end
            StAcc: begin
                best_upd = !timed_out_q;
                count_d  = count_q + W'(1);
`ifdef COLLATZ_SWEEP_TIMEOUT_EN
                if (timed_out_q) timeouts_d = timeouts_q + W'(1);
`endif
                // equality test before increment so n_hi = all-ones never wraps
                if (cur_n_q == n_hi_q) begin
                    busy_d   = 1'b0;
                    finish_d = 1'b1;
                    state_d  = StDone;
                end else begin
                    cur_n_d = cur_n_q + W'(1);
                    state_d = StKrst;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            n_hi_q      <= '0;
            cur_n_q     <= '0;
            kern_n_q    <= '0;
            ret_q       <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_hi_q      <= n_hi_d;
            cur_n_q     <= cur_n_d;
            kern_n_q    <= kern_n_d;
            ret_q       <= ret_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            finish_q    <= finish_d;
            timed_out_q <= timed_out_d;
        end
    end

`ifdef COLLATZ_SWEEP_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_q     <= '0;
            timeouts_q <= '0;
        end else begin
            wdog_q     <= wdog_d;
            timeouts_q <= timeouts_d;
        end
    end
    assign ret_timeouts = timeouts_q;
`else
    assign ret_timeouts = '0;
`endif

    collatz_sweep_best #(
        .W (W)
    ) u_best (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (best_clr),
        .upd        (best_upd),
        .cand_n     (cur_n_q),
        .cand_steps (ret_q),
        .max_steps  (ret_max_steps),
        .argmax     (ret_argmax)
    );

    assign busy       = busy_q;
    assign finish     = finish_q;
    assign ret_count  = count_q;
    assign kern_n     = kern_n_q;
    assign kern_rst_n = rst_n && (state_q != StKrst);
    assign kern_start = rst_n && (state_q == StKstart);

endmodule
